mem_channel_arbiter: RTL

Memory-side responder for the valid/ready request interface that compute cores drive toward program and data memory. Accepts read and write requests from NUM_CONSUMERS requesters (per-thread LSU/dcache channels or per-core fetchers). Arbitrates them onto NUM_CHANNELS parallel external memory ports. Returns read data and write completion with a ready pulse that stays up until the requester drops valid.

---
 rtl/mem_channel_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mem_channel_arbiter.sv
// mem_channel_arbiter: grants consumer read/write requests onto parallel external memory channels
// and relays completion back with a ready that is held until the consumer drops valid.
module mem_channel_arbiter #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1,
    parameter bit WRITE_ENABLE  = 1
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                 consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                 consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]                  mem_read_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_read_address,
    input  logic [NUM_CHANNELS-1:0]                  mem_read_ready,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_read_data,
    output logic [NUM_CHANNELS-1:0]                  mem_write_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_write_address,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_write_data,
    input  logic [NUM_CHANNELS-1:0]                  mem_write_ready
);
    localparam int IDX_W = NUM_CONSUMERS > 1 ? $clog2(NUM_CONSUMERS) : 1;
    localparam logic [2:0] IDLE           = 3'd0;
    localparam logic [2:0] READ_WAITING   = 3'd1;
    localparam logic [2:0] WRITE_WAITING  = 3'd2;
    localparam logic [2:0] READ_RELAYING  = 3'd3;
    localparam logic [2:0] WRITE_RELAYING = 3'd4;
    logic [2:0]               state [NUM_CHANNELS];
    logic [IDX_W-1:0]         idx [NUM_CHANNELS];
    logic [IDX_W-1:0]         grant_idx [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]  grant, grant_write;
    logic [NUM_CONSUMERS-1:0] claim, claim_next, taken;
    logic [NUM_CHANNELS-1:0]  write_valid_q;
    logic [NUM_CONSUMERS-1:0] write_ready_q;
    // Channels resolve in ascending order; each grant hides its consumer from higher channels.
    always_comb begin
        taken = claim;
        claim_next = claim;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            grant[c] = 1'b0;
            grant_write[c] = 1'b0;
            grant_idx[c] = '0;
            for (int i = 0; i < NUM_CONSUMERS; i++) begin
                if (state[c] == IDLE && !grant[c] && !taken[i] &&
                    (consumer_read_valid[i] || (WRITE_ENABLE && consumer_write_valid[i]))) begin
                    grant[c] = 1'b1;
                    grant_write[c] = !consumer_read_valid[i];
                    grant_idx[c] = IDX_W'(i);
                end
            end
            if (grant[c]) begin
                taken[grant_idx[c]] = 1'b1;
                claim_next[grant_idx[c]] = 1'b1;
            end
            if ((state[c] == READ_RELAYING && !consumer_read_valid[idx[c]]) ||
                (state[c] == WRITE_RELAYING && !consumer_write_valid[idx[c]]))
                claim_next[idx[c]] = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            claim               <= '0;
            consumer_read_ready <= '0;
            consumer_read_data  <= '0;
            write_ready_q       <= '0;
            mem_read_valid      <= '0;
            mem_read_address    <= '0;
            write_valid_q       <= '0;
            mem_write_address   <= '0;
            mem_write_data      <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state[c] <= IDLE;
                idx[c]   <= '0;
            end
        end else begin
            claim <= claim_next;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                case (state[c])
                    IDLE: if (grant[c]) begin
                        idx[c] <= grant_idx[c];
                        if (grant_write[c]) begin
                            write_valid_q[c]     <= 1'b1;
                            mem_write_address[c] <= consumer_write_address[grant_idx[c]];
                            mem_write_data[c]    <= consumer_write_data[grant_idx[c]];
                            state[c]             <= WRITE_WAITING;
                        end else begin
                            mem_read_valid[c]   <= 1'b1;
                            mem_read_address[c] <= consumer_read_address[grant_idx[c]];
                            state[c]            <= READ_WAITING;
                        end
                    end
                    READ_WAITING: if (mem_read_ready[c]) begin
                        mem_read_valid[c]           <= 1'b0;
                        consumer_read_data[idx[c]]  <= mem_read_data[c];
                        consumer_read_ready[idx[c]] <= 1'b1;
                        state[c]                    <= READ_RELAYING;
                    end
                    WRITE_WAITING: if (mem_write_ready[c]) begin
                        write_valid_q[c]      <= 1'b0;
                        write_ready_q[idx[c]] <= 1'b1;
                        state[c]              <= WRITE_RELAYING;
                    end
                    READ_RELAYING: if (!consumer_read_valid[idx[c]]) begin
                        consumer_read_ready[idx[c]] <= 1'b0;
                        state[c]                    <= IDLE;
                    end
                    WRITE_RELAYING: if (!consumer_write_valid[idx[c]]) begin
                        write_ready_q[idx[c]] <= 1'b0;
                        state[c]              <= IDLE;
                    end
                    default: state[c] <= IDLE;
                endcase
            end
        end
    end
    assign mem_write_valid      = WRITE_ENABLE ? write_valid_q : '0;
    assign consumer_write_ready = WRITE_ENABLE ? write_ready_q : '0;
endmodule
